// File: rtl/sysid_pkg.sv
// Shared constants for the system-ID check sequencer: FSM state encoding,
// result codes, slave word addresses and the word comparison helper.
package sysid_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RD_ID   = 3'd1;
  localparam logic [2:0] ST_WAIT_ID = 3'd2;
  localparam logic [2:0] ST_RD_TS   = 3'd3;
  localparam logic [2:0] ST_WAIT_TS = 3'd4;
  localparam logic [2:0] ST_CHECK   = 3'd5;
  localparam logic [2:0] ST_DONE    = 3'd6;

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_ID      = 2'd1;
  localparam logic [1:0] ERR_TS      = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  // ID mismatch is reported ahead of a timestamp mismatch.
  function automatic logic [1:0] check_code(input logic [31:0] id_w, input logic [31:0] ts_w,
                                            input logic [31:0] exp_id, input logic [31:0] exp_ts);
    logic [1:0] code;
    if (id_w != exp_id) begin
      code = ERR_ID;
    end else if (ts_w != exp_ts) begin
      code = ERR_TS;
    end else begin
      code = ERR_OK;
    end
    return code;
  endfunction

endpackage

// File: rtl/sysid_avm_read.sv
// Single Avalon-MM read engine: registered read strobe/address, waitrequest
// handling, fixed read-latency tracking and stall timeout detection.
module sysid_avm_read #(
  parameter int READ_LATENCY   = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_i,
  input  logic        addr_i,
  input  logic        waitrequest_i,
  input  logic [31:0] readdata_i,
  output logic        avm_read_o,
  output logic        avm_address_o,
  output logic        active_o,
  output logic        accept_o,
  output logic        valid_o,
  output logic        timeout_o,
  output logic [31:0] data_o
);

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]  LAT      = 2'(READ_LATENCY);

  logic        rd_q, rd_d;
  logic        addr_q, addr_d;
  logic        wait_q, wait_d;
  logic [1:0]  lat_q, lat_d;
  logic [15:0] tmo_q, tmo_d;
  logic        accept_s, timeout_s, valid_s;

  always_comb begin
    accept_s  = rd_q & ~waitrequest_i;
    // Abort on the TIMEOUT_CYCLES-th stalled cycle; strobe drops the cycle after.
    timeout_s = rd_q & waitrequest_i & (tmo_q == TMO_LAST);
    tmo_d     = (rd_q & waitrequest_i & ~timeout_s) ? (tmo_q + 16'd1) : 16'd0;
    rd_d      = rd_q;
    addr_d    = addr_q;
    wait_d    = wait_q;
    lat_d     = lat_q;
    if (READ_LATENCY == 0) begin
      valid_s = accept_s;
    end else begin
      valid_s = wait_q & (lat_q == LAT);
    end
    if (accept_s && (READ_LATENCY != 0)) begin
      wait_d = 1'b1;
      lat_d  = 2'd1;
    end else if (wait_q) begin
      if (lat_q == LAT) begin
        wait_d = 1'b0;
      end else begin
        lat_d = lat_q + 2'd1;
      end
    end else begin
      lat_d = lat_q;
    end
    if (accept_s || timeout_s) begin
      rd_d = 1'b0;
    end else begin
      rd_d = rd_q;
    end
    if (req_i) begin
      rd_d   = 1'b1;
      addr_d = addr_i;
    end else begin
      addr_d = addr_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_q   <= 1'b0;
      addr_q <= 1'b0;
      wait_q <= 1'b0;
      lat_q  <= 2'd0;
      tmo_q  <= 16'd0;
    end else begin
      rd_q   <= rd_d;
      addr_q <= addr_d;
      wait_q <= wait_d;
      lat_q  <= lat_d;
      tmo_q  <= tmo_d;
    end
  end

  assign avm_read_o    = rd_q;
  assign avm_address_o = addr_q;
  assign active_o      = rd_q;
  assign accept_o      = accept_s;
  assign valid_o       = valid_s;
  assign timeout_o     = timeout_s;
  assign data_o        = readdata_i;

endmodule

// File: rtl/sysid_check_ctrl.sv
// System-ID check sequencer: reads ID and timestamp words, compares, reports.
// Optional periodic re-check is enabled by defining SYSID_CHECK_PERIODIC_EN.
module sysid_check_ctrl
  import sysid_pkg::*;
#(
  parameter logic [31:0] EXP_ID         = 32'h00AA0000,
  parameter logic [31:0] EXP_TS         = 32'h5F95E88A,
  parameter int          READ_LATENCY   = 1,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter int          MAX_RETRIES    = 2,
  parameter int          AUTO_START     = 1
`ifdef SYSID_CHECK_PERIODIC_EN
  , parameter int        RECHECK_PERIOD = 1000000
`endif
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [1:0]  err_code,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  localparam logic [3:0] RETRY_MAX = 4'(MAX_RETRIES);
  localparam logic       AUTO_EN   = (AUTO_START != 0);

  logic [2:0]  state_q, state_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic [1:0]  err_q, err_d;
  logic [31:0] id_q, id_d;
  logic [31:0] ts_q, ts_d;
  logic [3:0]  retry_q, retry_d;
  logic        auto_q;
  logic        req_s, req_addr_s, trig_s, per_trig_s;
  logic        eng_active_s, eng_accept_s, eng_valid_s, eng_timeout_s;
  logic [31:0] eng_data_s;

  sysid_avm_read #(
    .READ_LATENCY   (READ_LATENCY),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rd (
    .clock         (clock),
    .reset         (reset),
    .req_i         (req_s),
    .addr_i        (req_addr_s),
    .waitrequest_i (avm_waitrequest),
    .readdata_i    (avm_readdata),
    .avm_read_o    (avm_read),
    .avm_address_o (avm_address),
    .active_o      (eng_active_s),
    .accept_o      (eng_accept_s),
    .valid_o       (eng_valid_s),
    .timeout_o     (eng_timeout_s),
    .data_o        (eng_data_s)
  );

`ifdef SYSID_CHECK_PERIODIC_EN
  localparam logic [31:0] PERIOD = 32'(RECHECK_PERIOD);
  logic [31:0] per_q, per_d;

  always_comb begin
    if ((state_q == ST_DONE) || start) begin
      per_d = PERIOD;
    end else if (per_q != 32'd0) begin
      per_d = per_q - 32'd1;
    end else begin
      per_d = per_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      per_q <= PERIOD;
    end else begin
      per_q <= per_d;
    end
  end

  assign per_trig_s = (per_q == 32'd0);
`else
  assign per_trig_s = 1'b0;
`endif

  assign trig_s = start | auto_q | per_trig_s;

  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    pass_d     = pass_q;
    err_d      = err_q;
    id_d       = id_q;
    ts_d       = ts_q;
    retry_d    = retry_q;
    req_s      = 1'b0;
    req_addr_s = SYSID_ADDR_ID;
    case (state_q)
      ST_IDLE: begin
        if (trig_s) begin
          state_d = ST_RD_ID;
          busy_d  = 1'b1;
          retry_d = 4'd0;
          req_s   = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD_ID: begin
        // An idle engine here means a retry after a timeout: relaunch the ID read.
        if (!eng_active_s) begin
          req_s = 1'b1;
        end else if (eng_valid_s) begin
          id_d       = eng_data_s;
          req_s      = 1'b1;
          req_addr_s = SYSID_ADDR_TS;
          state_d    = ST_RD_TS;
        end else if (eng_accept_s) begin
          state_d = ST_WAIT_ID;
        end else begin
          state_d = ST_RD_ID;
        end
      end
      ST_WAIT_ID: begin
        if (eng_valid_s) begin
          id_d       = eng_data_s;
          req_s      = 1'b1;
          req_addr_s = SYSID_ADDR_TS;
          state_d    = ST_RD_TS;
        end else begin
          state_d = ST_WAIT_ID;
        end
      end
      ST_RD_TS: begin
        if (eng_valid_s) begin
          ts_d    = eng_data_s;
          state_d = ST_CHECK;
        end else if (eng_accept_s) begin
          state_d = ST_WAIT_TS;
        end else begin
          state_d = ST_RD_TS;
        end
      end
      ST_WAIT_TS: begin
        if (eng_valid_s) begin
          ts_d    = eng_data_s;
          state_d = ST_CHECK;
        end else begin
          state_d = ST_WAIT_TS;
        end
      end
      ST_CHECK: begin
        state_d = ST_DONE;
        done_d  = 1'b1;
        err_d   = check_code(id_q, ts_q, EXP_ID, EXP_TS);
        pass_d  = (check_code(id_q, ts_q, EXP_ID, EXP_TS) == ERR_OK);
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
    if (eng_timeout_s) begin
      retry_d = retry_q + 4'd1;
      if (retry_q < RETRY_MAX) begin
        state_d = ST_RD_ID;
      end else begin
        state_d = ST_DONE;
        done_d  = 1'b1;
        pass_d  = 1'b0;
        err_d   = ERR_TIMEOUT;
      end
    end else begin
      retry_d = retry_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= ERR_OK;
      id_q    <= 32'd0;
      ts_q    <= 32'd0;
      retry_q <= 4'd0;
      auto_q  <= AUTO_EN;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      id_q    <= id_d;
      ts_q    <= ts_d;
      retry_q <= retry_d;
      auto_q  <= 1'b0;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign err_code = err_q;
  assign id_value = id_q;
  assign ts_value = ts_q;

endmodule

// File: tb/tb_sysid_check_ctrl.sv
// Directed bench for sysid_check_ctrl with a latency-1 Avalon slave model.
module tb_sysid_check_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        busy, done, pass;
  logic [1:0]  err_code;
  logic [31:0] id_value, ts_value;

  logic [31:0] id_word;
  logic [31:0] ts_word;
  int          stall_cfg = 0;
  bit          stall_all = 1'b0;
  int          stall_cnt = 0;
  logic        acc_q = 1'b0;
  logic        acc_addr = 1'b0;

  int n_assert = 0;
  int n_fail   = 0;
  int k;
  int rd_high, rd_rises;
  logic busy1, read1, addr1, pass3;
  logic [1:0] err3;

  always #5 clock = ~clock;

  assign avm_waitrequest = stall_all | (stall_cnt < stall_cfg);
  assign avm_readdata    = acc_q ? (acc_addr ? ts_word : id_word) : 32'hDEADBEEF;

  // Slave: data valid the cycle after accept; optional per-read stall count.
  always @(posedge clock) begin
    acc_q    <= avm_read & ~avm_waitrequest;
    acc_addr <= avm_address;
    if (avm_read && avm_waitrequest) stall_cnt <= stall_cnt + 1;
    else stall_cnt <= 0;
  end

  sysid_check_ctrl #(
    .EXP_ID         (32'h00AA0000),
    .EXP_TS         (32'h5F95E88A),
    .READ_LATENCY   (1),
    .TIMEOUT_CYCLES (8),
    .MAX_RETRIES    (2),
    .AUTO_START     (1)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .start           (start),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_waitrequest (avm_waitrequest),
    .avm_readdata    (avm_readdata),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .err_code        (err_code),
    .id_value        (id_value),
    .ts_value        (ts_value)
  );

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_read"}, {31'd0, avm_read}, 32'd0);
    chk({tag, "_addr"}, {31'd0, avm_address}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_pass"}, {31'd0, pass}, 32'd0);
    chk({tag, "_err"}, {30'd0, err_code}, 32'd0);
    chk({tag, "_id"}, id_value, 32'd0);
    chk({tag, "_ts"}, ts_value, 32'd0);
  endtask

  // Runs cycles until done (bounded); start_at=0 pulses start first, >0 pulses mid-run.
  task automatic run_to_done(input int start_at, output int kk);
    logic prev;
    kk = 0;
    rd_high = 0;
    rd_rises = 0;
    prev = avm_read;
    if (start_at == 0) start = 1'b1;
    while (kk < 200) begin
      cyc();
      start = 1'b0;
      kk++;
      if (avm_read) rd_high++;
      if (avm_read && !prev) rd_rises++;
      prev = avm_read;
      if (kk == 1) begin busy1 = busy; read1 = avm_read; addr1 = avm_address; end
      if (kk == 3) begin err3 = err_code; pass3 = pass; end
      if (kk == start_at) start = 1'b1;
      if (done) break;
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    int quiet;
    reset   = 1'b1;
    start   = 1'b0;
    id_word = 32'h00AA0000;
    ts_word = 32'h5F95E88A;
    cyc();
    cyc();
    chk_zero_outputs("rst");
    reset = 1'b0;

    // Auto run, matching slave
    run_to_done(-1, k);
    chk("t1_done_k", k, 32'd6);
    chk("t1_busy1", {31'd0, busy1}, 32'd1);
    chk("t1_read1", {31'd0, read1}, 32'd1);
    chk("t1_addr1", {31'd0, addr1}, 32'd0);
    chk("t1_pass", {31'd0, pass}, 32'd1);
    chk("t1_err", {30'd0, err_code}, 32'd0);
    chk("t1_id", id_value, 32'h00AA0000);
    chk("t1_ts", ts_value, 32'h5F95E88A);
    chk("t1_rises", rd_rises, 32'd2);
    cyc();
    chk("t1_done_pulse", {31'd0, done}, 32'd0);
    chk("t1_busy_after", {31'd0, busy}, 32'd0);

    // ID mismatch
    id_word = 32'h00AB0000;
    pulse_reset();
    run_to_done(-1, k);
    chk("t2_done_k", k, 32'd6);
    chk("t2_pass", {31'd0, pass}, 32'd0);
    chk("t2_err", {30'd0, err_code}, 32'd1);
    chk("t2_id", id_value, 32'h00AB0000);
    chk("t2_ts", ts_value, 32'h5F95E88A);

    // Timestamp mismatch
    id_word = 32'h00AA0000;
    ts_word = 32'h00000000;
    pulse_reset();
    run_to_done(-1, k);
    chk("t3_pass", {31'd0, pass}, 32'd0);
    chk("t3_err", {30'd0, err_code}, 32'd2);
    chk("t3_ts", ts_value, 32'h00000000);

    // External start; previous result holds during the run
    ts_word = 32'h5F95E88A;
    cyc();
    run_to_done(0, k);
    chk("t4_done_k", k, 32'd6);
    chk("t4_err_hold", {30'd0, err3}, 32'd2);
    chk("t4_pass_hold", {31'd0, pass3}, 32'd0);
    chk("t4_pass", {31'd0, pass}, 32'd1);
    chk("t4_err", {30'd0, err_code}, 32'd0);

    // Five stalled cycles per read
    stall_cfg = 5;
    pulse_reset();
    run_to_done(-1, k);
    chk("t5_done_k", k, 32'd16);
    chk("t5_pass", {31'd0, pass}, 32'd1);
    chk("t5_rises", rd_rises, 32'd2);
    chk("t5_rd_high", rd_high, 32'd12);

    // Permanent stall: three aborted attempts then timeout
    stall_cfg = 0;
    stall_all = 1'b1;
    pulse_reset();
    run_to_done(-1, k);
    chk("t6_done_k", k, 32'd27);
    chk("t6_err", {30'd0, err_code}, 32'd3);
    chk("t6_pass", {31'd0, pass}, 32'd0);
    chk("t6_rises", rd_rises, 32'd3);
    chk("t6_rd_high", rd_high, 32'd24);
    quiet = 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      quiet += int'(avm_read) + int'(busy);
    end
    chk("t6_quiet", quiet, 32'd0);
    stall_all = 1'b0;

    // Start while busy and start in DONE are both ignored
    pulse_reset();
    run_to_done(2, k);
    chk("t7_done_k", k, 32'd6);
    chk("t7_pass", {31'd0, pass}, 32'd1);
    start = 1'b1;
    cyc();
    start = 1'b0;
    quiet = 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      quiet += int'(avm_read) + int'(busy);
    end
    chk("t7_no_queue", quiet, 32'd0);

    // Reset during WAIT_TS, then the auto run repeats
    pulse_reset();
    for (int i = 0; i < 4; i++) cyc();
    chk("t8_wts_addr", {31'd0, avm_address}, 32'd1);
    chk("t8_wts_read", {31'd0, avm_read}, 32'd0);
    chk("t8_wts_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    cyc();
    chk_zero_outputs("t8_rst");
    reset = 1'b0;
    run_to_done(-1, k);
    chk("t8_done_k", k, 32'd6);
    chk("t8_pass", {31'd0, pass}, 32'd1);
    chk("t8_id", id_value, 32'h00AA0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
